a51_burst_cipher: RTL
=====================

# a51_burst_cipher

Self-contained A5/1 burst engine: accepts a 64-bit session key and 22-bit TDMA frame number, runs key/frame loading and 100 mixing clocks internally, then encrypts/decrypts a 228-bit burst pair (114 A→B bits followed by 114 B→A bits) as a 1-bit valid/ready stream. It sits between the burst formatter and the modulator interface. It drives its own three majority-clocked LFSRs, which use the same shift-left, feedback-into-bit-0 convention as the existing per-register LFSR block.

## Interface
- KEYLEN, 64, session key width (bits absorbed during LOAD_KEY)
- FRAMENUMLEN, 22, frame-number width (bits absorbed during LOAD_FRAME)
- MIXCYCLES, 100, majority-clocked cycles with output discarded
- HALFLEN, 114, bits per direction; burst = 2*HALFLEN beats
- clock  in  1  clock; all state updates on rising edge
- reset  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- key  in  KEYLEN  session key; key[i] is load bit i; sampled with start
- frame  in  FRAMENUMLEN  frame number; frame[i] is load bit i; sampled with start
- busy  out  1  high from the edge after accepted start until done
- in_valid  in  1  plaintext/ciphertext bit valid
- in_ready  out  1  engine accepts a bit this cycle
- in_data  in  1  input bit
- out_valid  out  1  output bit valid (registered)
- out_ready  in  1  downstream accepts output
- out_data  out  1  in_data XOR keystream bit
- out_last  out  1  high with output beats 114 and 228
- done  out  1  one-cycle pulse at end of burst

## Operation
- Registers: R1 19b (taps 13,16,17,18; clock bit 8), R2 22b (taps 20,21; clock bit 10), R3 23b (taps 7,20,21,22; clock bit 10).
- Step of a register: reg <= {reg[N-2:0], ^(reg & TAPMASK)}.
- Keystream bit: R1[18]^R2[21]^R3[22].
- Majority: maj = majority(R1[8],R2[10],R3[10]); a register steps only if its clock bit equals maj.
- FSM states: IDLE, LOAD_KEY, LOAD_FRAME, MIX, STREAM, DRAIN.
- IDLE: registers hold. On start=1, latch key/frame, zero R1..R3, clear counter, go to LOAD_KEY.
- LOAD_KEY: per cycle i=0..KEYLEN-1, step all three registers, then XOR key[i] into bit 0 of each. After the last bit, go to LOAD_FRAME.
- LOAD_FRAME: same as LOAD_KEY using frame[i], i=0..FRAMENUMLEN-1, then go to MIX.
- MIX: MIXCYCLES majority steps, output discarded, then go to STREAM.
- STREAM, per accepted beat (in_valid & in_ready):
  - compute the majority-stepped next state and write it to the registers;
  - out_data <= in_data ^ keystream(next state);
  - out_valid <= 1;
  - beat counter increments.
- Registers never advance without an accepted beat.
- in_ready = (state==STREAM) & (!out_valid | out_ready). It is 0 in all other states.
- out_valid clears on out_ready when no new beat is accepted in the same cycle. Simultaneous accept and drain reloads out_data; no bubble.
- After beat 2*HALFLEN is accepted, go to DRAIN. When out_valid is 0 (or drains that cycle), pulse done, drop busy, return to IDLE.
- start while not IDLE is ignored.
- Backpressure on out_ready stalls input; no bits are lost or duplicated.

## Timing
- Reset values: state IDLE, R1/R2/R3 0, counters 0, busy 0, in_ready 0, out_valid 0, out_data 0, out_last 0, done 0.
- Reset mid-burst aborts immediately with no done pulse.
- Edge E0 samples start.
  - Edges E1..E64 absorb key.
  - Edges E65..E86 absorb frame.
  - Edges E87..E186 mix.
  - in_ready first high in the cycle after E186 (out_ready don't-care).
- Input-to-output latency: 1 cycle (out_valid high the cycle after acceptance).
- Full-throughput burst: 228 consecutive beats; done on the edge after the last output is consumed.
- Minimum start-to-done: 187 + 228 + 1 cycles with out_ready held 1.
- New start is accepted the cycle after done (IDLE).

## Test plan
- Reference vector: key=64'hEFCDAB8967452312, frame=22'h134, in_data=0, out_ready=1.
  - First 32 out bits = 0x534EAA58, MSB first.
  - in_ready first high 187 cycles after start.
- Encrypt/decrypt round trip: feed random 228 bits, then rerun with same key/frame feeding the outputs → original bits recovered; out_last on beats 114 and 228 only.
- Backpressure: toggle out_ready randomly and in_valid randomly → output bit sequence identical to the throughput-1 run; no extra register steps (compare against reference model).
- start asserted during MIX and during STREAM → ignored; busy stays 1; exactly 228 outputs; single done pulse.
- Reset asserted at beat 50 → all outputs at reset values next cycle; new start reproduces the vector from the beginning.
- Back-to-back bursts: start in the cycle after done with frame=22'h135 → busy reasserts; keystream matches the reference model for the new frame.

Source files
------------

// File: rtl/a51_burst_cipher.sv
// A5/1 burst engine: loads key and frame number into three majority-clocked
// LFSRs, mixes, then XORs a 2*HALFLEN-bit valid/ready bit stream with the keystream.
module a51_burst_cipher #(
    parameter int KEYLEN      = 64,
    parameter int FRAMENUMLEN = 22,
    parameter int MIXCYCLES   = 100,
    parameter int HALFLEN     = 114
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [KEYLEN-1:0]      key,
    input  logic [FRAMENUMLEN-1:0] frame,
    output logic                   busy,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_data,
    output logic                   out_last,
    output logic                   done
);

    localparam int CNT_MAX = KEYLEN + FRAMENUMLEN + MIXCYCLES + 2 * HALFLEN;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [18:0] R1_TAPS = 19'h72000;   // bits 13,16,17,18
    localparam logic [21:0] R2_TAPS = 22'h300000;  // bits 20,21
    localparam logic [22:0] R3_TAPS = 23'h700080;  // bits 7,20,21,22

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KEY,
        LOAD_FRAME,
        MIX,
        STREAM,
        DRAIN
    } state_t;

    state_t                 state_q, state_d;
    logic [18:0]            r1_q, r1_d;
    logic [21:0]            r2_q, r2_d;
    logic [22:0]            r3_q, r3_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [KEYLEN-1:0]      key_q, key_d;
    logic [FRAMENUMLEN-1:0] frame_q, frame_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_data_q, out_data_d;
    logic                   out_last_q, out_last_d;
    logic                   done_q, done_d;
    logic                   in_ready_c;

    function automatic logic [18:0] step_r1(input logic [18:0] r);
        return {r[17:0], ^(r & R1_TAPS)};
    endfunction

    function automatic logic [21:0] step_r2(input logic [21:0] r);
        return {r[20:0], ^(r & R2_TAPS)};
    endfunction

    function automatic logic [22:0] step_r3(input logic [22:0] r);
        return {r[21:0], ^(r & R3_TAPS)};
    endfunction

    // Majority-clocked successor state and the keystream bit it produces.
    logic        maj;
    logic [18:0] r1_maj;
    logic [21:0] r2_maj;
    logic [22:0] r3_maj;
    logic        ks_next;

    always_comb begin
        maj     = (r1_q[8] & r2_q[10]) | (r1_q[8] & r3_q[10]) | (r2_q[10] & r3_q[10]);
        r1_maj  = (r1_q[8]  == maj) ? step_r1(r1_q) : r1_q;
        r2_maj  = (r2_q[10] == maj) ? step_r2(r2_q) : r2_q;
        r3_maj  = (r3_q[10] == maj) ? step_r3(r3_q) : r3_q;
        ks_next = r1_maj[18] ^ r2_maj[21] ^ r3_maj[22];
    end

    always_comb begin
        state_d     = state_q;
        r1_d        = r1_q;
        r2_d        = r2_q;
        r3_d        = r3_q;
        cnt_d       = cnt_q;
        key_d       = key_q;
        frame_d     = frame_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        in_ready_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key;
                    frame_d = frame;
                    r1_d    = '0;
                    r2_d    = '0;
                    r3_d    = '0;
                    cnt_d   = '0;
                    state_d = LOAD_KEY;
                end
            end

            LOAD_KEY: begin
                // key_q shifts right so bit 0 always holds the next load bit.
                r1_d  = step_r1(r1_q) ^ {18'd0, key_q[0]};
                r2_d  = step_r2(r2_q) ^ {21'd0, key_q[0]};
                r3_d  = step_r3(r3_q) ^ {22'd0, key_q[0]};
                key_d = key_q >> 1;
                if (cnt_q == CW'(KEYLEN - 1)) begin
                    cnt_d   = '0;
                    state_d = LOAD_FRAME;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            LOAD_FRAME: begin
                r1_d    = step_r1(r1_q) ^ {18'd0, frame_q[0]};
                r2_d    = step_r2(r2_q) ^ {21'd0, frame_q[0]};
                r3_d    = step_r3(r3_q) ^ {22'd0, frame_q[0]};
                frame_d = frame_q >> 1;
                if (cnt_q == CW'(FRAMENUMLEN - 1)) begin
                    cnt_d   = '0;
                    state_d = MIX;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            MIX: begin
                r1_d = r1_maj;
                r2_d = r2_maj;
                r3_d = r3_maj;
                if (cnt_q == CW'(MIXCYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = STREAM;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            STREAM: begin
                in_ready_c = !out_valid_q || out_ready;
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
                // An accepted beat reloads the output register, so drain+accept has no bubble.
                if (in_valid && in_ready_c) begin
                    r1_d        = r1_maj;
                    r2_d        = r2_maj;
                    r3_d        = r3_maj;
                    out_data_d  = in_data ^ ks_next;
                    out_valid_d = 1'b1;
                    out_last_d  = (cnt_q == CW'(HALFLEN - 1)) || (cnt_q == CW'(2 * HALFLEN - 1));
                    if (cnt_q == CW'(2 * HALFLEN - 1)) begin
                        cnt_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            DRAIN: begin
                if (!out_valid_q || out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            r1_q        <= '0;
            r2_q        <= '0;
            r3_q        <= '0;
            cnt_q       <= '0;
            key_q       <= '0;
            frame_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            r1_q        <= r1_d;
            r2_q        <= r2_d;
            r3_q        <= r3_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            frame_q     <= frame_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign in_ready  = in_ready_c;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign done      = done_q;

endmodule
